// File: rtl/mod_n_step_counter_pkg.sv
// Shared types and step decode for the modulo-N step counter.
// Imported by the interface, the next-state logic and the top.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_UP1,
        MODE_UP2,
        MODE_DOWN1
    } mode_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef struct packed {
        logic signed [2:0] step;
        dir_t              dir;
    } step_t;

    localparam logic signed [2:0] STEP_HOLD  = 3'sd0;
    localparam logic signed [2:0] STEP_UP1   = 3'sd1;
    localparam logic signed [2:0] STEP_UP2   = 3'sd2;
    localparam logic signed [2:0] STEP_DOWN1 = -3'sd1;

    function automatic step_t decode_step(input mode_t m);
        step_t r;
        r.step = STEP_HOLD;
        r.dir  = DIR_NONE;
        unique case (m)
            MODE_UP1: begin
                r.step = STEP_UP1;
                r.dir  = DIR_UP;
            end
            MODE_UP2: begin
                r.step = STEP_UP2;
                r.dir  = DIR_UP;
            end
            MODE_DOWN1: begin
                r.step = STEP_DOWN1;
                r.dir  = DIR_DOWN;
            end
            default: begin
                r.step = STEP_HOLD;
                r.dir  = DIR_NONE;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mod_n_step_counter_if.sv
// Control/status bundle of the step counter.
// master drives controls, slave is the counter.
interface mod_n_step_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) ();

    logic             En;
    mode_t            Mode;
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic [WIDTH-1:0] Count;
    logic             WrapUp;
    logic             WrapDown;

    modport master (
        output En, Mode, Load, LoadValue,
        input  Count, WrapUp, WrapDown
    );

    modport slave (
        input  En, Mode, Load, LoadValue,
        output Count, WrapUp, WrapDown
    );

endinterface

// File: rtl/mod_n_step_counter_next.sv
// Combinational next-count and wrap/clamp decode
// for one step of the modulo-N counter.
module mod_n_next
    import counter_pkg::*;
#(
    parameter int MOD   = 9,
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  mode_t            mode_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_up_o,
    output logic             wrap_dn_o
);

    localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

    step_t              st;
    logic signed [WIDTH:0] stepx;
    logic [WIDTH:0]     sum;
    logic               illegal;

    assign st      = decode_step(mode_i);
    assign stepx   = (WIDTH+1)'(st.step);
    assign sum     = {1'b0, count_i} + stepx;
    assign illegal = {1'b0, count_i} >= MODW;

    always_comb begin
        next_o    = count_i;
        wrap_up_o = 1'b0;
        wrap_dn_o = 1'b0;
        // an unreachable count recovers to 0 on any counting edge
        if (illegal) begin
            next_o = '0;
        end else if (st.dir == DIR_UP) begin
            if (sum >= MODW) begin
                next_o    = sat_i ? MAXV : WIDTH'(sum - MODW);
                wrap_up_o = 1'b1;
            end else begin
                next_o = sum[WIDTH-1:0];
            end
        end else if (st.dir == DIR_DOWN) begin
            if (count_i == '0) begin
                next_o    = sat_i ? '0 : MAXV;
                wrap_dn_o = 1'b1;
            end else begin
                next_o = sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mod_n_step_counter.sv
// Modulo-N +1/+2/-1 step counter with load and registered wrap pulses.
// Define COUNTER_SATURATE_EN to clamp at the range limits instead of wrapping.
module mod_n_step_counter
    import counter_pkg::*;
#(
    parameter int MOD   = 9,
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    mod_n_step_counter_if.slave  bus
);

    if (MOD < 3 || (2 ** WIDTH) < MOD) begin : g_param_chk
        $error("mod_n_step_counter: need MOD>=3 and 2**WIDTH>=MOD");
    end

    localparam logic [WIDTH:0] MODW = (WIDTH+1)'(MOD);

`ifdef COUNTER_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_dn_q, wrap_dn_d;
    mode_t            eff_mode;
    logic             load_ok;

    assign eff_mode = bus.En ? bus.Mode : MODE_HOLD;
    assign load_ok  = {1'b0, bus.LoadValue} < MODW;

    mod_n_next #(
        .MOD   (MOD),
        .WIDTH (WIDTH)
    ) u_next (
        .count_i   (count_q),
        .mode_i    (eff_mode),
        .sat_i     (SAT),
        .next_o    (count_d),
        .wrap_up_o (wrap_up_d),
        .wrap_dn_o (wrap_dn_d)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q   <= '0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
        end else if (bus.Load) begin
            count_q   <= load_ok ? bus.LoadValue : '0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
        end
    end

    assign bus.Count    = count_q;
    assign bus.WrapUp   = wrap_up_q;
    assign bus.WrapDown = wrap_dn_q;

endmodule

// File: tb/tb_mod_n_step_counter.sv
// Scoreboard bench for mod_n_step_counter, MOD=9 WIDTH=4.
module tb_mod_n_step_counter;
    import counter_pkg::*;

    typedef struct packed {
        logic [3:0] c;
        logic       wu;
        logic       wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod_n_step_counter_if #(.WIDTH(4)) bus ();

    mod_n_step_counter #(.MOD(9), .WIDTH(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_c   = 0;
    bit   m_wu  = 0;
    bit   m_wd  = 0;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic drive(input bit r, input bit ld, input int lv,
                         input bit en, input int md);
        int t;
        @(negedge clk);
        rst           = r;
        bus.Load      = ld;
        bus.LoadValue = 4'(lv);
        bus.En        = en;
        bus.Mode      = mode_t'(md[1:0]);
        m_wu = 0;
        m_wd = 0;
        if (r) begin
            m_c = 0;
        end else if (ld) begin
            m_c = (lv < 9) ? lv : 0;
        end else if (en && (md == 1 || md == 2)) begin
            t = m_c + md;
            if (t >= 9) begin
                m_c  = SAT ? 8 : t - 9;
                m_wu = 1;
            end else begin
                m_c = t;
            end
        end else if (en && md == 3) begin
            if (m_c == 0) begin
                m_c  = SAT ? 0 : 8;
                m_wd = 1;
            end else begin
                m_c = m_c - 1;
            end
        end
        sb.push_back('{c: 4'(m_c), wu: m_wu, wd: m_wd});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5, 1, 1);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
                n_bad++;
                $display("FAIL reset[%0d] got c=%0d wu=%b wd=%b want c=%0d wu=%b wd=%b",
                         i, bus.Count, bus.WrapUp, bus.WrapDown, e.c, e.wu, e.wd);
            end
        end
        n_cmp++;
        if (bus.Count !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_zero got %0d want 0", bus.Count);
        end
    endtask

    task automatic test_up1();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 1);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
                n_bad++;
                $display("FAIL up1[%0d] got c=%0d wu=%b wd=%b want c=%0d wu=%b wd=%b",
                         i, bus.Count, bus.WrapUp, bus.WrapDown, e.c, e.wu, e.wd);
            end
            n_cmp++;
            if (bus.Count !== 4'((i + 1) % 9) || bus.WrapUp !== (i == 8)) begin
                n_bad++;
                $display("FAIL up1_seq[%0d] got c=%0d wu=%b want c=%0d wu=%b",
                         i, bus.Count, bus.WrapUp, (i + 1) % 9, i == 8);
            end
        end
    endtask

    task automatic test_up2();
        exp_t e;
        int   st[5][2] = '{'{1, 7}, '{0, 2}, '{0, 2}, '{1, 8}, '{0, 2}};
        for (int i = 0; i < 5; i++) begin
            drive(0, st[i][0] == 1, st[i][1], 1, st[i][1]);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
                n_bad++;
                $display("FAIL up2[%0d] got c=%0d wu=%b wd=%b want c=%0d wu=%b wd=%b",
                         i, bus.Count, bus.WrapUp, bus.WrapDown, e.c, e.wu, e.wd);
            end
        end
    endtask

    task automatic test_down_hold();
        exp_t e;
        drive(0, 1, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, i < 3, i < 3 ? 3 : 1);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
                n_bad++;
                $display("FAIL down_hold[%0d] got c=%0d wu=%b wd=%b want c=%0d wu=%b wd=%b",
                         i, bus.Count, bus.WrapUp, bus.WrapDown, e.c, e.wu, e.wd);
            end
        end
    endtask

    task automatic test_load_priority();
        exp_t e;
        int   st[6][3] = '{'{0, 1, 5}, '{0, 1, 12}, '{0, 0, 0},
                          '{0, 1, 3}, '{0, 0, 0}, '{1, 1, 6}};
        for (int i = 0; i < 6; i++) begin
            drive(st[i][0] == 1, st[i][1] == 1, st[i][2], 1, 2 - (i % 2));
            e = sb.pop_front();
            n_cmp++;
            if ({bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
                n_bad++;
                $display("FAIL load_prio[%0d] got c=%0d wu=%b wd=%b want c=%0d wu=%b wd=%b",
                         i, bus.Count, bus.WrapUp, bus.WrapDown, e.c, e.wu, e.wd);
            end
        end
        drive(0, 1, 3, 0, 0);
        void'(sb.pop_front());
        drive(0, 0, 0, 1, 1);
        void'(sb.pop_front());
        drive(1, 0, 0, 1, 1);
        e = sb.pop_front();
        n_cmp++;
        if (bus.Count !== 4'd0 || {bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
            n_bad++;
            $display("FAIL reset_mid got c=%0d want c=%0d", bus.Count, e.c);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   st[5][3] = '{'{1, 7, 0}, '{0, 0, 2}, '{0, 0, 1},
                          '{1, 0, 0}, '{0, 0, 3}};
        for (int i = 0; i < 5; i++) begin
            drive(0, st[i][0] == 1, st[i][1], 1, st[i][2]);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
                n_bad++;
                $display("FAIL limit[%0d] got c=%0d wu=%b wd=%b want c=%0d wu=%b wd=%b",
                         i, bus.Count, bus.WrapUp, bus.WrapDown, e.c, e.wu, e.wd);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            drive($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)));
            e = sb.pop_front();
            n_cmp++;
            if ({bus.Count, bus.WrapUp, bus.WrapDown} !== e) begin
                n_bad++;
                $display("FAIL random[%0d] got c=%0d wu=%b wd=%b want c=%0d wu=%b wd=%b",
                         i, bus.Count, bus.WrapUp, bus.WrapDown, e.c, e.wu, e.wd);
            end
        end
    endtask

    initial begin
        bus.En        = 1'b0;
        bus.Mode      = MODE_HOLD;
        bus.Load      = 1'b0;
        bus.LoadValue = '0;
        test_reset();
        test_up1();
        test_up2();
        test_down_hold();
        test_load_priority();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_n_step_counter.md
# mod_n_step_counter

Parametrised modulo-N step counter: the next generation of the 0..8 up/down step counter, generalised to any modulus. Counts by +1, +2 or −1 (or holds) per cycle, selected by a 2-bit mode. Adds a count enable, synchronous parallel load and registered wrap pulses. It is the sequencing counter for the FSM lab datapaths: it feeds display decoders and its wrap pulses cascade into other counters.

## Interface
- MOD, default 9: counter modulus; the count range is 0..MOD−1; must be ≥ 3.
- WIDTH, default 4: count width; must satisfy 2^WIDTH ≥ MOD (elaboration-time assertion).
- Clock  input  1  sole clock, rising edge.
- Reset  input  1  synchronous, active-high.
- En  input  1  count enable; when 0, the count holds regardless of Mode.
- Mode  input  2  step select: 00 hold, 01 +1, 10 +2, 11 −1.
- Load  input  1  synchronous parallel load.
- LoadValue  input  WIDTH  value to load.
- Count  output  WIDTH  current count (the state register itself).
- WrapUp  output  1  one-cycle pulse: the last update crossed MOD−1→0 upward.
- WrapDown  output  1  one-cycle pulse: the last update crossed 0→MOD−1 downward.

## Operation
- Priority at each rising Clock edge, highest first: Reset, then Load, then (En and Mode).
- Reset=1: Count←0, WrapUp←0, WrapDown←0. All three outputs are 0 out of reset.
- Load=1:
  - Count←LoadValue if LoadValue<MOD; otherwise Count←0.
  - Wrap flags←0.
  - Mode and En are ignored that cycle.
- En=0, or Mode=00: Count holds; wrap flags←0.
- Up step s∈{1,2}:
  - Compute sum=Count+s in WIDTH+1 bits.
  - If sum≥MOD: Count←sum−MOD and WrapUp←1.
  - Otherwise Count←sum.
  - Example (MOD=9): 7 +2 → 0 with wrap; 8 +2 → 1 with wrap.
- Down step:
  - If Count==0: Count←MOD−1 and WrapDown←1.
  - Otherwise Count←Count−1.
- WrapUp and WrapDown are never asserted in the same cycle.
- Count never leaves 0..MOD−1. If the register holds an illegal value (not reachable from reset), the next non-reset, non-load edge forces Count←0.

## Timing
- Single-cycle latency: Count and the wrap flags reflect the inputs sampled at the previous rising edge. There is no extra output-delay stage; this differs from the legacy counter.
- Wrap flags are registered and asserted during exactly the cycle in which the wrapped Count value is visible.
- Reset asserted mid-count takes effect at the next edge, even with Load or En active.
- All inputs must meet setup to Clock; there are no asynchronous paths.

## Configuration
- Macro COUNTER_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - An up step that would reach ≥MOD gives Count←MOD−1.
  - A down step from 0 leaves Count at 0.
  - WrapUp or WrapDown pulses whenever a step was clamped, including when Count was already at the limit.
- Undefined: modulo wrap behaviour as in Operation.
- Load and Reset behave identically in both builds.

## Structure
- Shared package counter_pkg:
  - typedef enum logic [1:0] mode_t {MODE_HOLD, MODE_UP1, MODE_UP2, MODE_DOWN1}.
  - Step constants.
  - The step-decode function returning signed step and direction.
- One combinational sub-module, mod_n_next:
  - Inputs: current count, mode_t, saturate flag.
  - Outputs: next count and wrap-up/wrap-down indications.
  - Parametrised on MOD and WIDTH.
- The top holds the state and flag registers plus load/enable priority.

## Test plan
All scenarios use MOD=9, WIDTH=4.
- Reset held 2 cycles with Load=1, LoadValue=5, En=1, Mode=01 → Count=0, WrapUp=0, WrapDown=0.
- From 0: En=1, Mode=01 for 10 cycles → Count 1,2,…,8,0,1; WrapUp high only in the cycle Count=0.
- Load 7, then Mode=10 for 2 cycles → Count 0 with WrapUp=1, then 2 with WrapUp=0. Load 8, then Mode=10 → Count 1, WrapUp=1.
- From 0: Mode=11 for 3 cycles → 8 with WrapDown=1, then 7, then 6. En=0 with Mode=01 → Count stays 6, both flags 0.
- Load=1 with LoadValue=5, En=1, Mode=10 in the same cycle → Count=5 (load wins). Load with LoadValue=12 → Count=0. Reset asserted mid-run of Mode=01 at Count=4 → Count=0 at the next edge.
- COUNTER_SATURATE_EN build:
  - From 7, Mode=10 → Count 8 with WrapUp=1; a further Mode=01 keeps Count 8 with WrapUp=1.
  - From 0, Mode=11 → Count 0 with WrapDown=1.
